mem_port_arbiter: RTL

- Shares the single-ported memory bus between the fetch stage (instruction port, I) and the memory stage (data port, D).
- Holds at most one bus transaction in flight. D has priority over I, with a starvation guard so fetch always makes progress.
- Supports fetch flush: the decode-stage discard/jump redirect drops an in-flight fetch response so that stale instructions never reach decode.

---
 rtl/mollusc_mem_pkg.sv | 22 ++
 rtl/mem_arb_select.sv | 33 +++
 rtl/mem_port_arbiter.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/mollusc_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mollusc_mem_pkg
// Description : Shared types and defaults for the memory-port arbiter slice.
// Revision    : 1.0 - initial release
// ============================================================================
package mollusc_mem_pkg;

    localparam int c_ADDR_W_DEFAULT = 32;
    localparam int c_DATA_W_DEFAULT = 32;
    localparam int c_STARVE_W       = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE_I = 3'd1,
        ST_ISSUE_D = 3'd2,
        ST_WAIT_I  = 3'd3,
        ST_WAIT_D  = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_arb_select.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_select
// Description : Combinational D-over-I priority select with starvation guard.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arb_select
    import mollusc_mem_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic [2:0]            state,
    input  logic                  i_req,
    input  logic                  i_flush,
    input  logic                  d_req,
    input  logic [c_STARVE_W-1:0] starve_cnt,
    output logic                  i_req_eff,
    output logic                  i_ack,
    output logic                  d_ack
);

    localparam logic [c_STARVE_W-1:0] c_LIMIT = c_STARVE_W'(STARVE_LIMIT);

    logic w_idle;

    assign w_idle    = (state == ST_IDLE);
    assign i_req_eff = i_req & ~i_flush;
    // D loses only when fetch has waited through STARVE_LIMIT data grants
    assign d_ack     = w_idle & d_req & (~i_req_eff | (starve_cnt < c_LIMIT));
    assign i_ack     = w_idle & i_req_eff & ~d_ack;

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one memory bus between fetch (I) and data (D) ports,
//               one transaction in flight, with fetch-flush response dropping.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mollusc_mem_pkg::*;
#(
    parameter int ADDR_W       = c_ADDR_W_DEFAULT,
    parameter int DATA_W       = c_DATA_W_DEFAULT,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_flush,
    output logic              i_ack,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_we,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              bus_req,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_we,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_accept,
    input  logic              bus_rvalid,
    input  logic [DATA_W-1:0] bus_rdata
);

    localparam logic [c_STARVE_W-1:0] c_LIMIT = c_STARVE_W'(STARVE_LIMIT);

    state_t                r_state;
    state_t                w_state_next;
    logic                  r_drop;
    logic [c_STARVE_W-1:0] r_starve_cnt;
    logic                  w_i_req_eff;

    mem_arb_select #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_select (
        .state      (r_state),
        .i_req      (i_req),
        .i_flush    (i_flush),
        .d_req      (d_req),
        .starve_cnt (r_starve_cnt),
        .i_req_eff  (w_i_req_eff),
        .i_ack      (i_ack),
        .d_ack      (d_ack)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (d_ack) begin
                    w_state_next = ST_ISSUE_D;
                end else if (i_ack) begin
                    w_state_next = ST_ISSUE_I;
                end
            end
            ST_ISSUE_I: if (bus_accept) w_state_next = ST_WAIT_I;
            ST_ISSUE_D: if (bus_accept) w_state_next = ST_WAIT_D;
            ST_WAIT_I:  if (bus_rvalid) w_state_next = ST_IDLE;
            ST_WAIT_D:  if (bus_rvalid) w_state_next = ST_IDLE;
            default:    w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus_req      <= 1'b0;
            bus_we       <= 1'b0;
            i_rvalid     <= 1'b0;
            d_rvalid     <= 1'b0;
            r_drop       <= 1'b0;
            r_starve_cnt <= '0;
        end else begin
            i_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (d_ack) begin
                        bus_req <= 1'b1;
                        bus_we  <= d_we;
                        if (w_i_req_eff) begin
                            r_starve_cnt <= (r_starve_cnt < c_LIMIT) ? r_starve_cnt + 1'b1 : c_LIMIT;
                        end else begin
                            r_starve_cnt <= '0;
                        end
                    end else if (i_ack) begin
                        bus_req      <= 1'b1;
                        bus_we       <= 1'b0;
                        r_starve_cnt <= '0;
                        r_drop       <= 1'b0;
                    end
                end
                ST_ISSUE_I: begin
                    if (bus_accept) bus_req <= 1'b0;
                    if (i_flush)    r_drop  <= 1'b1;
                end
                ST_ISSUE_D: begin
                    if (bus_accept) bus_req <= 1'b0;
                end
                ST_WAIT_I: begin
                    // a flush arriving with the response still kills it
                    if (bus_rvalid) begin
                        i_rvalid <= ~(r_drop | i_flush);
                        r_drop   <= 1'b0;
                    end else if (i_flush) begin
                        r_drop <= 1'b1;
                    end
                end
                ST_WAIT_D: begin
                    if (bus_rvalid) d_rvalid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus_addr  <= {ADDR_W{1'bx}};
            bus_wdata <= {DATA_W{1'bx}};
            i_rdata   <= {DATA_W{1'bx}};
            d_rdata   <= {DATA_W{1'bx}};
        end else begin
            if (d_ack) begin
                bus_addr  <= d_addr;
                bus_wdata <= d_wdata;
            end else if (i_ack) begin
                bus_addr  <= i_addr;
            end
            if (r_state == ST_WAIT_I && bus_rvalid) begin
                i_rdata <= bus_rdata;
            end
            if (r_state == ST_WAIT_D && bus_rvalid) begin
                d_rdata <= bus_we ? {DATA_W{1'bx}} : bus_rdata;
            end
        end
    end

endmodule
`default_nettype wire
